// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALTED control FSM and the IF/ID pipeline register.
// Optional feature: define PC_OVERFLOW_TRAP_EN to halt (and flag pc_overflow) instead of wrapping past PC 2047.
module if_stage #(
    parameter logic [10:0] RESET_PC    = 11'd0,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [10:0] branch_target,
    input  logic [31:0] imem_data,
    output logic [10:0] imem_addr,
    output logic [31:0] if_instr,
    output logic [10:0] if_pc_plus1,
    output logic        if_valid,
    output logic        halted,
    output logic        pc_overflow
);

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]  state_reg,       state_next;
    logic [10:0] pc_reg,          pc_next;
    logic [31:0] if_instr_reg,    if_instr_next;
    logic [10:0] if_pc_plus1_reg, if_pc_plus1_next;
    logic        if_valid_reg,    if_valid_next;

    logic [10:0] pc_plus1;
    logic        halt_fetch;

    assign pc_plus1   = pc_reg + 11'd1;
    assign halt_fetch = (imem_data[31:26] == HALT_OPCODE);

`ifdef PC_OVERFLOW_TRAP_EN
    logic pc_overflow_reg, pc_overflow_next;
    logic pc_at_top;

    assign pc_at_top = (pc_reg == 11'h7FF);
`endif

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        if_instr_next    = if_instr_reg;
        if_pc_plus1_next = if_pc_plus1_reg;
        if_valid_next    = if_valid_reg;
`ifdef PC_OVERFLOW_TRAP_EN
        pc_overflow_next = pc_overflow_reg;
`endif
        case (state_reg)
            ST_BOOT: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                // A redirect wins over a decode stall: the stalled instruction is on the wrong path anyway.
                if (branch_taken) begin
                    pc_next       = branch_target;
                    if_valid_next = 1'b0;
                end else if (!stall) begin
                    if_instr_next    = imem_data;
                    if_pc_plus1_next = pc_plus1;
                    if_valid_next    = 1'b1;
                    pc_next          = pc_plus1;
                    if (halt_fetch) begin
                        state_next = ST_HALTED;
                    end
`ifdef PC_OVERFLOW_TRAP_EN
                    if (pc_at_top) begin
                        pc_next          = pc_reg;
                        pc_overflow_next = 1'b1;
                        state_next       = ST_HALTED;
                    end
`endif
                end
            end
            ST_HALTED: begin
                // The halt may sit in a branch shadow, so a redirect resumes fetching.
                if (branch_taken) begin
                    pc_next       = branch_target;
                    if_valid_next = 1'b0;
                    state_next    = ST_RUN;
                end else if (!stall) begin
                    if_valid_next = 1'b0;
                end
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_BOOT;
            pc_reg          <= RESET_PC;
            if_instr_reg    <= 32'h0;
            if_pc_plus1_reg <= 11'd0;
            if_valid_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            if_instr_reg    <= if_instr_next;
            if_pc_plus1_reg <= if_pc_plus1_next;
            if_valid_reg    <= if_valid_next;
        end
    end

`ifdef PC_OVERFLOW_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_overflow_reg <= 1'b0;
        end else begin
            pc_overflow_reg <= pc_overflow_next;
        end
    end

    assign pc_overflow = pc_overflow_reg;
`else
    assign pc_overflow = 1'b0;
`endif

    assign imem_addr   = pc_reg;
    assign if_instr    = if_instr_reg;
    assign if_pc_plus1 = if_pc_plus1_reg;
    assign if_valid    = if_valid_reg;
    assign halted      = (state_reg == ST_HALTED);

endmodule
